// File: rtl/dmem_responder.sv
// Word-organised data-memory responder: one outstanding load/store, byte-lane
// writes, programmable wait states, ready/valid on request and response.

module dmem_lane #(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = 10
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] idx,
    input  logic [7:0]       wbyte,
    output logic [7:0]       rbyte
);
    logic [7:0] mem [DEPTH_WORDS];

    // Contents survive rst; read is asynchronous so the old word is seen on a commit edge.
    always_ff @(posedge clk)
        if (we) mem[idx] <= wbyte;

    assign rbyte = mem[idx];
endmodule

module dmem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_STATES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int          NUM_LANES = 4;
    localparam int          IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN      = 33'(DEPTH_WORDS) * 33'd4;
    localparam logic [3:0]  CNT_INIT  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                      state;
    logic [3:0]                  cnt;
    logic                        a_we;
    logic [31:0]                 a_addr;
    logic [NUM_LANES-1:0][7:0]   a_wdata;
    logic [NUM_LANES-1:0]        a_be;

    logic                        accept;
    logic                        enter_resp;
    logic                        commit;
    logic                        e_we;
    logic [31:0]                 e_addr;
    logic [NUM_LANES-1:0][7:0]   e_wdata;
    logic [NUM_LANES-1:0]        e_be;
    logic [31:0]                 off;
    logic                        err;
    logic [IDX_W-1:0]            idx;
    logic [NUM_LANES-1:0]        lane_we;
    logic [NUM_LANES-1:0][7:0]   rd_word;

    assign accept = req_valid && req_ready;

    // With zero wait states RESP is entered on the accept edge, so the live request is used.
    assign e_we    = (state == IDLE) ? req_we    : a_we;
    assign e_addr  = (state == IDLE) ? req_addr  : a_addr;
    assign e_wdata = (state == IDLE) ? req_wdata : a_wdata;
    assign e_be    = (state == IDLE) ? req_be    : a_be;

    assign off = e_addr - BASE_ADDR;
    assign err = (e_addr[1:0] != 2'b00) || ({1'b0, off} >= SPAN);
    assign idx = off[IDX_W+1:2];

    assign enter_resp = (accept && (WAIT_STATES == 0)) || (state == WAIT && cnt == 4'd0);
    assign commit     = enter_resp && e_we && !err;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        assign lane_we[g] = commit && e_be[g];
        dmem_lane #(.DEPTH_WORDS(DEPTH_WORDS), .IDX_W(IDX_W)) u_lane (
            .clk   (clk),
            .we    (lane_we[g]),
            .idx   (idx),
            .wbyte (e_wdata[g]),
            .rbyte (rd_word[g])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
            a_we      <= 1'b0;
            a_addr    <= 32'd0;
            a_wdata   <= '0;
            a_be      <= '0;
        end else if (enter_resp) begin
            state     <= RESP;
            req_ready <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= err;
            rsp_rdata <= (!err && !e_we) ? rd_word : 32'd0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    a_we      <= req_we;
                    a_addr    <= req_addr;
                    a_wdata   <= req_wdata;
                    a_be      <= req_be;
                    state     <= WAIT;
                    cnt       <= CNT_INIT;
                    req_ready <= 1'b0;
                end
                WAIT: cnt <= cnt - 4'd1;
                RESP: if (rsp_ready) begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    rsp_rdata <= 32'd0;
                    rsp_err   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios plus random traffic against a
// word-array reference model; a second instance covers zero wait states.

module tb_dmem_responder;
    localparam int          WS   = 2;
    localparam int          DW   = 1024;
    localparam bit [31:0]   BASE = 32'h0000_0000;

    logic        clk = 1'b0, rst = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [3:0]  req_be = '0;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    logic        z_req_valid = 1'b0, z_req_we = 1'b0, z_rsp_ready = 1'b0;
    logic [31:0] z_req_addr = '0, z_req_wdata = '0;
    logic [3:0]  z_req_be = '0;
    logic        z_req_ready, z_rsp_valid, z_rsp_err;
    logic [31:0] z_rsp_rdata;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(DW), .WAIT_STATES(WS), .BASE_ADDR(BASE)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    dmem_responder #(.DEPTH_WORDS(DW), .WAIT_STATES(0), .BASE_ADDR(BASE)) u_dut0 (
        .clk(clk), .rst(rst),
        .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
        .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_be(z_req_be),
        .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready),
        .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
    );

    int        n_assert = 0;
    int        n_fail   = 0;
    bit [31:0] model_mem [int];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit model_err(input bit [31:0] a);
        bit [31:0] o;
        o = a - BASE;
        return (a % 4 != 0) || (longint'(o) >= longint'(DW) * 4);
    endfunction

    function automatic void model_txn(input bit we, input bit [31:0] a, input bit [31:0] wd,
                                      input bit [3:0] be, output bit [31:0] rd, output bit e);
        bit [31:0] cur;
        int        w;
        e  = model_err(a);
        rd = 0;
        if (e) return;
        w   = int'((a - BASE) / 4);
        cur = model_mem.exists(w) ? model_mem[w] : 32'd0;
        if (we) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) cur[8*b +: 8] = wd[8*b +: 8];
            model_mem[w] = cur;
        end else begin
            rd = cur;
        end
    endfunction

    // One full transaction on the WS instance. Latency counts the accept cycle as cycle 1,
    // so rsp_valid must be seen WS+1 cycles in; the response is then held for 'hold' cycles.
    task automatic txn(input bit we, input bit [31:0] a, input bit [31:0] wd, input bit [3:0] be,
                       input int hold, input string tag);
        bit [31:0] exp_rd;
        bit        exp_err;
        int        lat;
        check({tag, ".req_ready"}, req_ready, 1);
        req_valid = 1; req_we = we; req_addr = a; req_wdata = wd; req_be = be;
        @(posedge clk); #1;
        model_txn(we, a, wd, be, exp_rd, exp_err);
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            // Requester noise while busy must be ignored.
            req_valid = 1'($urandom); req_we = 1'($urandom);
            req_addr = $urandom & 32'hFC; req_wdata = $urandom; req_be = 4'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        req_valid = 0;
        check({tag, ".latency"}, 32'(lat), 32'(WS + 1));
        check({tag, ".rsp_valid"}, rsp_valid, 1);
        check({tag, ".rsp_err"}, rsp_err, exp_err);
        check({tag, ".rsp_rdata"}, rsp_rdata, exp_rd);
        check({tag, ".busy"}, req_ready, 0);
        repeat (hold) begin
            @(posedge clk); #1;
            check({tag, ".hold_valid"}, rsp_valid, 1);
            check({tag, ".hold_rdata"}, rsp_rdata, exp_rd);
            check({tag, ".hold_err"}, rsp_err, exp_err);
            check({tag, ".hold_busy"}, req_ready, 0);
        end
        rsp_ready = 1;
        @(posedge clk); #1;
        rsp_ready = 0;
        check({tag, ".done_valid"}, rsp_valid, 0);
        check({tag, ".done_ready"}, req_ready, 1);
        check({tag, ".done_rdata"}, rsp_rdata, 0);
        check({tag, ".done_err"}, rsp_err, 0);
    endtask

    initial begin
        bit [31:0] a, zaddr, zdata;
        bit        acc, was_we;
        int        prev;

        // Asynchronous reset: outputs settle before any clock edge.
        #2 rst = 1;
        #1;
        check("rst.req_ready", req_ready, 1);
        check("rst.rsp_valid", rsp_valid, 0);
        check("rst.rsp_rdata", rsp_rdata, 0);
        check("rst.rsp_err", rsp_err, 0);
        @(posedge clk); #1 rst = 0;

        txn(0, 32'h10, 0, 4'hF, 0, "rd10");
        txn(1, 32'h40, 32'hDEAD_BEEF, 4'hF, 0, "wr40");
        txn(0, 32'h40, 0, 4'h0, 0, "rd40");
        txn(1, 32'h40, 32'h0000_AA00, 4'b0010, 0, "wrlane");
        txn(0, 32'h40, 0, 4'hF, 0, "rdlane");
        check("lane_model", model_mem[16], 32'hDEAD_AAEF);
        txn(1, 32'h40, 32'h1111_1111, 4'h0, 0, "wrbe0");
        txn(0, 32'h40, 0, 4'hF, 0, "rdbe0");
        txn(0, 32'h42, 0, 4'hF, 0, "rdmis");
        txn(1, 32'h1000, 32'hCAFE_F00D, 4'hF, 0, "wroob");
        txn(0, 32'h0, 0, 4'hF, 0, "rd0");
        txn(0, 32'h40, 0, 4'hF, 5, "bp");

        // Reset during WAIT drops the write and the response.
        check("rstw.req_ready", req_ready, 1);
        req_valid = 1; req_we = 1; req_addr = 32'h80; req_wdata = 32'h1234_5678; req_be = 4'hF;
        @(posedge clk); #1;
        req_valid = 0;
        #2 rst = 1;
        #1;
        check("rstw.req_ready", req_ready, 1);
        check("rstw.rsp_valid", rsp_valid, 0);
        @(posedge clk); #1 rst = 0;
        repeat (4) begin
            @(posedge clk); #1;
            check("rstw.no_rsp", rsp_valid, 0);
        end
        txn(0, 32'h80, 0, 4'hF, 0, "rd80");

        for (int i = 0; i < 40; i++) begin
            case ($urandom % 8)
                6:       a = 32'h1000 + ($urandom % 64) * 4;
                5:       a = (32'h40 + ($urandom % 16) * 4) | (1 + $urandom % 3);
                7:       a = 32'hFFFF_F000 | ($urandom & 32'hFFC);
                default: a = 32'h40 + ($urandom % 16) * 4;
            endcase
            txn(1'($urandom), a, $urandom, 4'($urandom), int'($urandom % 3), "rand");
        end

        // Zero-wait instance: continuous requests and rsp_ready, write/read pairs.
        z_rsp_ready = 1; z_req_valid = 1; z_req_be = 4'hF;
        zaddr = ($urandom % DW) * 4; zdata = $urandom;
        z_req_we = 1; z_req_addr = zaddr; z_req_wdata = zdata;
        prev = -1;
        for (int cyc = 0; cyc < 24; cyc++) begin
            acc    = z_req_valid && z_req_ready;
            was_we = z_req_we;
            @(posedge clk); #1;
            if (acc) begin
                check("z.rsp_valid", z_rsp_valid, 1);
                check("z.rsp_err", z_rsp_err, 0);
                check("z.rsp_rdata", z_rsp_rdata, was_we ? 32'd0 : zdata);
                if (prev >= 0) check("z.spacing", 32'(cyc - prev), 2);
                prev = cyc;
                if (was_we) begin
                    z_req_we = 0;
                end else begin
                    zaddr = ($urandom % DW) * 4; zdata = $urandom;
                    z_req_we = 1; z_req_addr = zaddr; z_req_wdata = zdata;
                end
            end else begin
                check("z.pulse", z_rsp_valid, 0);
            end
        end
        check("z.accepts_seen", 32'(prev), 22);
        z_req_valid = 0; z_rsp_ready = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
